palette_fader: RTL and testbench

- Per-level block palette unit with timed transitions; generalises the fixed 8-level, 4-colour palette lookup.
- On a LEVEL change it cross-fades every colour channel from the current palette to the new level's palette, one LSB per fade step, with steps paced by frame ticks.
- A separate line-clear flash overlay forces all outputs to full white for a programmable number of frames.
- Sits between game-state logic and the pixel colour mapper. It replaces direct palette lookup.

---
 rtl/palette_pkg.sv | 48 ++++
 rtl/palette_rom.sv | 23 ++
 rtl/palette_fader.sv | 147 ++++++++++++++
 tb/tb_palette_fader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// palette_pkg: shared types and the default level palette table.
//   DEFAULT_CH_W   : channel width the table is authored in (one nibble per channel)
//   colour_t       : one R,G,B colour at DEFAULT_CH_W bits per channel, R in the MSBs
//   fade_state_t   : fader state encoding
//   DEFAULT_TABLE  : 8 levels x 4 colours
//   table_nibble() : one channel nibble of the table, level and colour taken modulo table size
//   expand_nibble(): nibble replicated across 32 bits; the low CH_W bits form a wider channel
package palette_pkg;

   localparam int unsigned DEFAULT_CH_W = 4;
   localparam int unsigned TABLE_LEVELS = 8;
   localparam int unsigned TABLE_COLORS = 4;

   typedef logic [3*DEFAULT_CH_W-1:0] colour_t;

   typedef enum logic {IDLE, FADE} fade_state_t;

   localparam colour_t DEFAULT_TABLE [TABLE_LEVELS][TABLE_COLORS] = '{
      '{12'h5df, 12'h06f, 12'h000, 12'hfff},
      '{12'haf0, 12'h8d0, 12'h000, 12'hfff},
      '{12'hf7f, 12'he0d, 12'h000, 12'hfff},
      '{12'h6e6, 12'h06f, 12'h000, 12'hfff},
      '{12'h6fa, 12'hf06, 12'h000, 12'hfff},
      '{12'h5f9, 12'h78f, 12'h000, 12'hfff},
      '{12'hf30, 12'h888, 12'h000, 12'hfff},
      '{12'h74f, 12'hb02, 12'h000, 12'hfff}
   };

   // slot 0 = B (lowest bits), 1 = G, 2 = R
   function automatic logic [3:0] table_nibble(input int unsigned level,
                                               input int unsigned colour,
                                               input int unsigned slot);
      logic [2:0] l;
      logic [1:0] ci;
      colour_t    c;
      l  = 3'(level);
      ci = 2'(colour);
      c  = DEFAULT_TABLE[l][ci];
      return 4'(c >> (slot * 4));
   endfunction

   // Bit b of the result is n[b % 4], so truncating to CH_W keeps the nibble pattern
   // repeating upward; valid for CH_W up to 32.
   function automatic logic [31:0] expand_nibble(input logic [3:0] n);
      return {8{n}};
   endfunction

endpackage

// File: rtl/palette_rom.sv
// palette_rom: combinational lookup of a whole level palette.
//   level   : level index (taken modulo 8 into the default table)
//   palette : NUM_COLORS colours, colour i at [i*3*CH_W +: 3*CH_W], R,G,B from MSB;
//             colours with index >= 4 repeat colours 0..3
module palette_rom
   import palette_pkg::*;
#(
   parameter int unsigned NUM_COLORS = 4,
   parameter int unsigned CH_W       = DEFAULT_CH_W,
   parameter int unsigned LVL_W      = 3
) (
   input  logic [LVL_W-1:0]             level,
   output logic [NUM_COLORS*3*CH_W-1:0] palette
);

   for (genvar c = 0; c < NUM_COLORS; c++) begin : g_colour
      for (genvar s = 0; s < 3; s++) begin : g_chan
         assign palette[(c*3+s)*CH_W +: CH_W] =
            CH_W'(expand_nibble(table_nibble(32'(level), c, s)));
      end
   end

endmodule

// File: rtl/palette_fader.sv
// palette_fader: level palette with per-LSB cross-fade and a white flash overlay.
//   CLK          : system clock
//   RESET_N      : asynchronous active-low reset
//   LEVEL        : requested level
//   FRAME_TICK   : one-cycle pulse per video frame, paces fade steps and the flash
//   FLASH_REQ    : one-cycle pulse, (re)starts the white flash
//   COLORS       : registered packed palette, colour i at [i*3*CH_W +: 3*CH_W]
//   BUSY         : fade in progress
//   FLASH_ACTIVE : flash overlay active
//   FADE_DONE    : one-cycle pulse when a fade completes
module palette_fader
   import palette_pkg::*;
#(
   parameter int unsigned NUM_LEVELS   = 8,
   parameter int unsigned NUM_COLORS   = 4,
   parameter int unsigned CH_W         = DEFAULT_CH_W,
   parameter int unsigned STEP_FRAMES  = 2,
   parameter int unsigned FLASH_FRAMES = 4,
   localparam int unsigned LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
   localparam int unsigned PAL_W       = NUM_COLORS * 3 * CH_W
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [LVL_W-1:0] LEVEL,
   input  logic             FRAME_TICK,
   input  logic             FLASH_REQ,
   output logic [PAL_W-1:0] COLORS,
   output logic             BUSY,
   output logic             FLASH_ACTIVE,
   output logic             FADE_DONE
);

   localparam int unsigned NUM_CH = NUM_COLORS * 3;
   localparam int unsigned STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
   localparam int unsigned FL_W   = $clog2(FLASH_FRAMES + 1);

   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_FRAMES - 1);
   localparam logic [FL_W-1:0]   FLASH_LOAD = FL_W'(FLASH_FRAMES);

   fade_state_t      state_q, state_d;
   logic [LVL_W-1:0] tgt_q, tgt_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [FL_W-1:0]  flash_q, flash_d;
   logic [PAL_W-1:0] cur_q, cur_d;
   logic [PAL_W-1:0] colors_q;
   logic             done_q, done_d;

   logic [PAL_W-1:0] tgt_palette;
   logic [PAL_W-1:0] reset_palette;
   logic [PAL_W-1:0] stepped;

   palette_rom #(
      .NUM_COLORS (NUM_COLORS),
      .CH_W       (CH_W),
      .LVL_W      (LVL_W)
   ) u_rom (
      .level   (tgt_q),
      .palette (tgt_palette)
   );

   // Constant level-0 palette used as the reset value of the working and output palettes.
   for (genvar c = 0; c < NUM_COLORS; c++) begin : g_rst_colour
      for (genvar s = 0; s < 3; s++) begin : g_rst_chan
         assign reset_palette[(c*3+s)*CH_W +: CH_W] =
            CH_W'(expand_nibble(table_nibble(0, c, s)));
      end
   end

   // Each channel moves one LSB toward its target; compare-then-step never wraps.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_step
      logic [CH_W-1:0] cur_ch, tgt_ch;
      assign cur_ch = cur_q[k*CH_W +: CH_W];
      assign tgt_ch = tgt_palette[k*CH_W +: CH_W];
      assign stepped[k*CH_W +: CH_W] = (cur_ch < tgt_ch) ? cur_ch + CH_W'(1) :
                                       (cur_ch > tgt_ch) ? cur_ch - CH_W'(1) : cur_ch;
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      cur_d   = cur_q;
      done_d  = 1'b0;
      flash_d = flash_q;

      unique case (state_q)
         IDLE: begin
            if (LEVEL != tgt_q) begin
               tgt_d   = LEVEL;
               step_d  = '0;
               state_d = FADE;
            end
         end
         FADE: begin
            // A retarget keeps the step phase and the current colours, so no visible jump.
            if (LEVEL != tgt_q) begin
               tgt_d = LEVEL;
            end else if (cur_q == tgt_palette) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            if (FRAME_TICK) begin
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  cur_d  = stepped;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A request in the same cycle as a tick reloads rather than decrements.
      if (FLASH_REQ) begin
         flash_d = FLASH_LOAD;
      end else if (FRAME_TICK && (flash_q != '0)) begin
         flash_d = flash_q - FL_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         tgt_q    <= '0;
         step_q   <= '0;
         flash_q  <= '0;
         cur_q    <= reset_palette;
         colors_q <= reset_palette;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         step_q   <= step_d;
         flash_q  <= flash_d;
         cur_q    <= cur_d;
         colors_q <= (flash_q != '0) ? '1 : cur_q;
         done_q   <= done_d;
      end
   end

   assign COLORS       = colors_q;
   assign BUSY         = (state_q == FADE);
   assign FLASH_ACTIVE = (flash_q != '0);
   assign FADE_DONE    = done_q;

endmodule

// File: tb/tb_palette_fader.sv
module tb_palette_fader;

   localparam int NCH = 12;
   localparam int SF  = 1;
   localparam int FF  = 4;

   localparam logic [11:0] TBL [8][4] = '{
      '{12'h5df, 12'h06f, 12'h000, 12'hfff},
      '{12'haf0, 12'h8d0, 12'h000, 12'hfff},
      '{12'hf7f, 12'he0d, 12'h000, 12'hfff},
      '{12'h6e6, 12'h06f, 12'h000, 12'hfff},
      '{12'h6fa, 12'hf06, 12'h000, 12'hfff},
      '{12'h5f9, 12'h78f, 12'h000, 12'hfff},
      '{12'hf30, 12'h888, 12'h000, 12'hfff},
      '{12'h74f, 12'hb02, 12'h000, 12'hfff}
   };

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic [2:0]  LEVEL = 3'd0;
   logic        FRAME_TICK = 1'b0;
   logic        FLASH_REQ = 1'b0;
   logic [47:0] colors1, colors2;
   logic        busy1, busy2, fa1, fa2, done1, done2;

   palette_fader #(
      .NUM_LEVELS(8), .NUM_COLORS(4), .CH_W(4), .STEP_FRAMES(1), .FLASH_FRAMES(4)
   ) u_dut (
      .CLK(CLK), .RESET_N(RESET_N), .LEVEL(LEVEL), .FRAME_TICK(FRAME_TICK),
      .FLASH_REQ(FLASH_REQ), .COLORS(colors1), .BUSY(busy1), .FLASH_ACTIVE(fa1),
      .FADE_DONE(done1)
   );

   palette_fader #(
      .NUM_LEVELS(8), .NUM_COLORS(4), .CH_W(4), .STEP_FRAMES(2), .FLASH_FRAMES(4)
   ) u_dut_slow (
      .CLK(CLK), .RESET_N(RESET_N), .LEVEL(LEVEL), .FRAME_TICK(FRAME_TICK),
      .FLASH_REQ(FLASH_REQ), .COLORS(colors2), .BUSY(busy2), .FLASH_ACTIVE(fa2),
      .FADE_DONE(done2)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [47:0] col;
      logic        busy;
      logic        fa;
      logic        done;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int d0;

   // reference model of u_dut (STEP_FRAMES=1)
   int m_cur[NCH];
   int m_tgt, m_step, m_fl;
   bit m_fade;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // channel k: colour k/3, k%3 = 0 is B (lowest nibble)
   function automatic int tgt_ch(input int lvl, input int k);
      logic [11:0] c;
      c = TBL[lvl % 8][k / 3];
      return int'((c >> ((k % 3) * 4)) & 12'hf);
   endfunction

   function automatic logic [47:0] pack_cur();
      logic [47:0] v;
      for (int k = 0; k < NCH; k++) v[k*4 +: 4] = 4'(m_cur[k]);
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) m_cur[k] = tgt_ch(0, k);
      m_tgt = 0; m_step = 0; m_fl = 0; m_fade = 0;
   endtask

   always @(negedge CLK) begin
      if (RESET_N) begin
         if (done1) done_seen++;
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_eq("sb_colors", colors1, mon_e.col);
            check_eq("sb_busy", busy1, mon_e.busy);
            check_eq("sb_flash_active", fa1, mon_e.fa);
            check_eq("sb_fade_done", done1, mon_e.done);
         end
      end
   end

   task automatic cycle(input logic [2:0] lvl, input logic tick, input logic flash);
      int n_cur[NCH];
      int n_tgt, n_step, n_fl;
      bit n_fade, n_done, at_tgt;
      exp_t e;
      LEVEL = lvl; FRAME_TICK = tick; FLASH_REQ = flash;
      n_cur = m_cur; n_tgt = m_tgt; n_step = m_step; n_fade = m_fade; n_done = 0;
      at_tgt = 1;
      for (int k = 0; k < NCH; k++) if (m_cur[k] != tgt_ch(m_tgt, k)) at_tgt = 0;
      if (!m_fade) begin
         if (int'(lvl) != m_tgt) begin
            n_tgt = int'(lvl); n_step = 0; n_fade = 1;
         end
      end else begin
         if (int'(lvl) != m_tgt) n_tgt = int'(lvl);
         else if (at_tgt) begin
            n_fade = 0; n_done = 1;
         end
         if (tick) begin
            if (m_step == SF - 1) begin
               n_step = 0;
               for (int k = 0; k < NCH; k++) begin
                  if (m_cur[k] < tgt_ch(m_tgt, k)) n_cur[k] = m_cur[k] + 1;
                  else if (m_cur[k] > tgt_ch(m_tgt, k)) n_cur[k] = m_cur[k] - 1;
               end
            end else begin
               n_step = m_step + 1;
            end
         end
      end
      if (flash) n_fl = FF;
      else if (tick && m_fl > 0) n_fl = m_fl - 1;
      else n_fl = m_fl;
      e.col  = (m_fl != 0) ? 48'hffff_ffff_ffff : pack_cur();
      e.busy = n_fade;
      e.fa   = (n_fl != 0);
      e.done = n_done;
      @(posedge CLK);
      m_cur = n_cur; m_tgt = n_tgt; m_step = n_step; m_fade = n_fade; m_fl = n_fl;
      sb_q.push_back(e);
      @(negedge CLK);
      #1;
      FRAME_TICK = 1'b0; FLASH_REQ = 1'b0;
   endtask

   task automatic apply_reset();
      RESET_N = 1'b0; LEVEL = 3'd0; FRAME_TICK = 1'b0; FLASH_REQ = 1'b0;
      model_reset();
      sb_q.delete();
      #1;
      check_eq("rst_colors", colors1, 48'hfff_000_06f_5df);
      check_eq("rst_busy", busy1, 1'b0);
      check_eq("rst_flash_active", fa1, 1'b0);
      check_eq("rst_fade_done", done1, 1'b0);
      check_eq("rst_slow_colors", colors2, 48'hfff_000_06f_5df);
      repeat (2) @(negedge CLK);
      #1 RESET_N = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      apply_reset();

      // first fade step 0 -> 1, and pacing on the STEP_FRAMES=2 instance
      cycle(3'd1, 1'b0, 1'b0);
      cycle(3'd1, 1'b1, 1'b0);
      cycle(3'd1, 1'b0, 1'b0);
      check_eq("step_c0", colors1[11:0], 12'h6ee);
      check_eq("step_c1", colors1[23:12], 12'h17e);
      check_eq("step_c2", colors1[35:24], 12'h000);
      check_eq("step_c3", colors1[47:36], 12'hfff);
      check_eq("step_busy", busy1, 1'b1);
      check_eq("pace_hold", colors2[11:0], 12'h5df);
      check_eq("pace_busy", busy2, 1'b1);
      cycle(3'd1, 1'b1, 1'b0);
      cycle(3'd1, 1'b0, 1'b0);
      check_eq("pace_step", colors2[11:0], 12'h6ee);
      check_eq("step2_c0", colors1[11:0], 12'h7fd);

      // completion after 15 ticks total
      for (int i = 0; i < 13; i++) begin
         cycle(3'd1, 1'b1, 1'b0);
         cycle(3'd1, 1'b0, 1'b0);
      end
      check_eq("done_c0", colors1[11:0], 12'haf0);
      check_eq("done_c1", colors1[23:12], 12'h8d0);
      check_eq("done_pulse", done_seen, 1);
      cycle(3'd1, 1'b0, 1'b0);
      cycle(3'd1, 1'b1, 1'b0);
      check_eq("done_once", done_seen, 1);
      check_eq("done_idle", busy1, 1'b0);

      // retarget 0 -> 1 then 6 after three steps
      apply_reset();
      d0 = done_seen;
      cycle(3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(3'd1, 1'b1, 1'b0);
      cycle(3'd1, 1'b0, 1'b0);
      check_eq("rt_c0", colors1[11:0], 12'h8fc);
      cycle(3'd6, 1'b0, 1'b0);
      check_eq("rt_busy", busy1, 1'b1);
      for (int i = 0; i < 40 && m_fade; i++) cycle(3'd6, 1'b1, 1'b0);
      cycle(3'd6, 1'b0, 1'b0);
      cycle(3'd6, 1'b0, 1'b0);
      check_eq("rt_done_count", done_seen - d0, 1);
      check_eq("rt_final", colors1, 48'hfff_000_888_f30);
      check_eq("rt_idle", busy1, 1'b0);

      // flash with a restart at tick 2 (request and tick in the same cycle)
      cycle(3'd6, 1'b0, 1'b1);
      check_eq("fl_active", fa1, 1'b1);
      cycle(3'd6, 1'b1, 1'b0);
      check_eq("fl_white", colors1, 48'hffff_ffff_ffff);
      cycle(3'd6, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(3'd6, 1'b1, 1'b0);
      check_eq("fl_extended", fa1, 1'b1);
      cycle(3'd6, 1'b1, 1'b0);
      check_eq("fl_ended", fa1, 1'b0);
      check_eq("fl_last_white", colors1, 48'hffff_ffff_ffff);
      cycle(3'd6, 1'b0, 1'b0);
      check_eq("fl_restore", colors1, 48'hfff_000_888_f30);

      // flash over a running fade, then reset mid-fade and mid-flash
      cycle(3'd2, 1'b0, 1'b0);
      cycle(3'd2, 1'b1, 1'b1);
      cycle(3'd2, 1'b1, 1'b0);
      cycle(3'd2, 1'b1, 1'b0);
      check_eq("mid_busy", busy1, 1'b1);
      check_eq("mid_flash", fa1, 1'b1);
      apply_reset();

      // change and revert before any step: enters FADE, then finishes at once
      d0 = done_seen;
      cycle(3'd1, 1'b0, 1'b0);
      cycle(3'd0, 1'b0, 1'b0);
      cycle(3'd0, 1'b0, 1'b0);
      cycle(3'd0, 1'b0, 1'b0);
      check_eq("revert_done", done_seen - d0, 1);
      check_eq("revert_idle", busy1, 1'b0);
      check_eq("revert_colors", colors1, 48'hfff_000_06f_5df);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
